// File: rtl/data_mem_responder.sv
// data_mem_responder
//   64-bit doubleword data memory behind a valid/ready request channel and a
//   valid/ready response channel, with a programmable wait time between
//   request acceptance and response. Only one transaction is in flight.
//
// Ports
//   CLK, Reset          rising-edge clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_addr            byte address (must be doubleword aligned, in range)
//   req_wdata           store data
//   resp_valid/ready    response handshake
//   resp_rdata          load data; 0 for stores and errors
//   resp_err            misaligned or out-of-range request
//   busy                a transaction is in flight
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW       = $clog2(DEPTH);
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;

  logic        cap_write;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;

  logic        acc_write;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic        acc_err;
  logic        mem_we;

  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  // Next state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (ZERO_LAT) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The storage access happens on the edge entering RESP. With zero latency
  // that is the acceptance edge itself, so the live request is used instead
  // of the captured copy.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx = acc_addr[AW+2:3];
  assign acc_err = (acc_addr[2:0] != 3'd0) || (acc_addr[63:AW+3] != '0);
  // Reset gating keeps an aborted store from landing in storage.
  assign mem_we  = enter_resp & acc_write & ~acc_err & ~Reset;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 64'd0;
      cap_wdata <= 64'd0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (acc_write || acc_err) ? 64'd0 : mem[acc_idx];
        err_q   <= acc_err;
      end else if (state == RESP && resp_ready) begin
        rdata_q <= 64'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
